logic16_arbiter: RTL and testbench

LOGIC16_ARBITER -- requirements
Module: logic16_arbiter

---
 rtl/logic16_arbiter.sv | 171 +++++++++++++++++
 tb/tb_logic16_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic16_arbiter.sv
// Two-requester round-robin arbiter in front of a registered bitwise logic unit.
// Define LOGIC16_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module logic16_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             out_id,
  output logic             busy
);

  // Handshake: req is a level held until the matching one-cycle gnt; the
  // operands are captured at the accept edge, so the requester may change
  // them (and must drop req) during its gnt cycle.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  state_t           state_q, state_d;
  logic             id_q, id_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_id_q, out_id_d;

  logic             accept;
  logic             winner;

  function automatic logic [WIDTH-1:0] apply_op(input logic [1:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = ~a;
    endcase
    return r;
  endfunction

  assign accept = (state_q == S_IDLE) && (req0 || req1);

`ifdef LOGIC16_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = !req0;
  end
`else
  // last_id remembers the most recent winner; reset to 1 so requester 0
  // takes the first tie.
  logic last_id_q, last_id_d;

  always_comb begin
    if (req0 && req1) begin
      winner = !last_id_q;
    end else begin
      winner = !req0;
    end
  end

  always_comb begin
    last_id_d = last_id_q;
    if (accept) begin
      last_id_d = winner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id_q <= 1'b1;
    end else begin
      last_id_q <= last_id_d;
    end
  end
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    gnt0      = (state_q == S_EXEC) && !id_q;
    gnt1      = (state_q == S_EXEC) && id_q;
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    out       = out_q;
    out_id    = out_id_q;
  end

  // Operand capture on accept; result registered as EXEC hands over to DONE.
  always_comb begin
    id_d     = id_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    out_d    = out_q;
    out_id_d = out_id_q;
    if (accept) begin
      id_d = winner;
      if (winner) begin
        op_d = op1;
        a_d  = a1;
        b_d  = b1;
      end else begin
        op_d = op0;
        a_d  = a0;
        b_d  = b0;
      end
    end
    if (state_q == S_EXEC) begin
      out_d    = apply_op(op_q, a_q, b_q);
      out_id_d = id_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q     <= 1'b0;
      op_q     <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
      out_q    <= '0;
      out_id_q <= 1'b0;
    end else begin
      id_q     <= id_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      out_q    <= out_d;
      out_id_q <= out_id_d;
    end
  end

endmodule

// File: tb/tb_logic16_arbiter.sv
// Bench for logic16_arbiter: directed scenarios plus a randomized run scored
// against a cycle-count model of accept/grant/result timing.
module tb_logic16_arbiter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1;
  logic [1:0]   op0, op1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, out_valid, out_id, busy;
  logic [W-1:0] out;

  int errors = 0;
  int checks = 0;

  logic [W:0] exp_q[$];

  logic16_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .out(out),
    .out_valid(out_valid), .out_id(out_id), .busy(busy)
  );

  // clock/reset
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] model_op(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // driver tasks
  task automatic clear_inputs();
    req0 = 0; req1 = 0; op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic drive_req(input int id, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
    if (id == 0) begin
      req0 = 1; op0 = op; a0 = a; b0 = b;
    end else begin
      req1 = 1; op1 = op; a1 = a; b1 = b;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #1;
    checks++;
    if ({gnt0, gnt1, out_valid, out_id, busy} !== 5'b0 || out !== '0) begin
      errors++;
      $display("FAIL reset_initial: gnt0=%b gnt1=%b valid=%b id=%b busy=%b out=%h, want all 0",
               gnt0, gnt1, out_valid, out_id, busy, out);
    end
    req0 = 1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (gnt0 !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_accept: gnt0=%b busy=%b, want 0 0", gnt0, busy);
      end
    end
    req0 = 0;
    rst_n = 1;
  endtask

  task automatic test_single_op();
    @(negedge clk);
    drive_req(0, 2'b01, 16'h00F0, 16'h0F00);
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_gnt: gnt0=%b gnt1=%b valid=%b busy=%b, want 1 0 0 1",
               gnt0, gnt1, out_valid, busy);
    end
    req0 = 0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out !== 16'h0FF0 || out_id !== 1'b0 || gnt0 !== 1'b0) begin
      errors++;
      $display("FAIL single_result: valid=%b out=%h id=%b gnt0=%b, want 1 0ff0 0 0",
               out_valid, out, out_id, gnt0);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out !== 16'h0FF0) begin
      errors++;
      $display("FAIL single_after: valid=%b busy=%b out=%h, want 0 0 0ff0", out_valid, busy, out);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_req(0, 2'b10, 16'hFFFF, 16'h0000);
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_setup: gnt0=%b busy=%b, want 1 1", gnt0, busy);
    end
    req0 = 0;
    #1 rst_n = 0;
    #1;
    checks++;
    if ({gnt0, gnt1, out_valid, out_id, busy} !== 5'b0 || out !== '0) begin
      errors++;
      $display("FAIL reset_mid_clear: gnt0=%b gnt1=%b valid=%b id=%b busy=%b out=%h, want all 0",
               gnt0, gnt1, out_valid, out_id, busy, out);
    end
    @(negedge clk);
    rst_n = 1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_release: valid=%b gnt0=%b gnt1=%b busy=%b, want 0 0 0 0",
                 out_valid, gnt0, gnt1, busy);
      end
    end
  endtask

  task automatic test_tie();
    int phase, exp_id;
    do_reset();
    op0 = 2'b10; a0 = 16'h1234; b0 = 16'h0000;
    op1 = 2'b10; a1 = 16'h5678; b1 = 16'h0000;
    req0 = 1; req1 = 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      phase = k % 3;
`ifdef LOGIC16_ARB_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = (k / 3) % 2;
`endif
      checks++;
      if (gnt0 !== (phase == 0 && exp_id == 0) || gnt1 !== (phase == 0 && exp_id == 1)) begin
        errors++;
        $display("FAIL tie_gnt k=%0d: gnt0=%b gnt1=%b, want grant to %0d only when phase 0",
                 k, gnt0, gnt1, exp_id);
      end
      checks++;
      if (out_valid !== (phase == 1)) begin
        errors++;
        $display("FAIL tie_valid k=%0d: valid=%b want %b", k, out_valid, phase == 1);
      end
      if (phase == 1) begin
        checks++;
        if (out_id !== exp_id[0] || out !== (exp_id == 1 ? 16'h5678 : 16'h1234)) begin
          errors++;
          $display("FAIL tie_result k=%0d: id=%b out=%h, want id %0d", k, out_id, out, exp_id);
        end
        req0 = 1; req1 = 1;
      end else if (phase == 0) begin
        if (exp_id == 0) req0 = 0;
        else req1 = 0;
      end
    end
    req0 = 0; req1 = 0;
  endtask

  task automatic test_opcodes();
    logic [W-1:0] exp_tab[4] = '{16'hAA00, 16'hFFAA, 16'h55AA, 16'h5555};
    int id;
    for (int op = 0; op < 4; op++) begin
      id = op % 2;
      @(negedge clk);
      drive_req(id, op[1:0], 16'hAAAA, 16'hFF00);
      @(negedge clk);
      checks++;
      if (gnt0 !== (id == 0) || gnt1 !== (id == 1)) begin
        errors++;
        $display("FAIL opcode_gnt op=%0d: gnt0=%b gnt1=%b, want grant to %0d", op, gnt0, gnt1, id);
      end
      req0 = 0; req1 = 0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out !== exp_tab[op] || out_id !== id[0]) begin
        errors++;
        $display("FAIL opcode_result op=%0d: valid=%b out=%h id=%b, want 1 %h %0d",
                 op, out_valid, out, out_id, exp_tab[op], id);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignored();
    int n_g0, n_g1, n_v;
    n_g0 = 0; n_g1 = 0; n_v = 0;
    @(negedge clk);
    drive_req(0, 2'b00, 16'hFFFF, 16'h0F0F);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_g0 += int'(gnt0);
      n_g1 += int'(gnt1);
      n_v  += int'(out_valid);
      if (k == 0) drive_req(1, 2'b01, 16'h1111, 16'h2222);
      if (k == 0) req0 = 0;
      if (k == 1) req1 = 0;
    end
    checks++;
    if (n_g1 != 0 || n_g0 != 1 || n_v != 1) begin
      errors++;
      $display("FAIL ignored_req: gnt0s=%0d gnt1s=%0d valids=%0d, want 1 0 1", n_g0, n_g1, n_v);
    end
    checks++;
    if (out !== 16'h0F0F || out_id !== 1'b0) begin
      errors++;
      $display("FAIL ignored_out: out=%h id=%b, want 0f0f 0", out, out_id);
    end
  endtask

  // Model: an accept decided at cycle c shows gnt at c+1, the result at c+2,
  // and the next accept may be decided at c+3.
  task automatic test_random();
    int gnt_at[int];
    bit valid_at[int];
    int cyc, next_free, last_w, accepted, w;
    bit dropped0, dropped1, exp_v, exp_busy;
    logic [W:0] ent;
    logic [W-1:0] hold;
    do_reset();
    exp_q.delete();
    cyc = 0; next_free = 0; last_w = 1; accepted = 0; hold = '0;
    while (cyc < 60000 && (accepted < 10000 || req0 || req1 || exp_q.size() != 0)) begin
      @(negedge clk);
      cyc++;
      dropped0 = 0; dropped1 = 0;
      checks++;
      if (gnt0 !== (gnt_at.exists(cyc) && gnt_at[cyc] == 0) ||
          gnt1 !== (gnt_at.exists(cyc) && gnt_at[cyc] == 1)) begin
        errors++;
        $display("FAIL rand_gnt cyc=%0d: gnt0=%b gnt1=%b, want winner %0d",
                 cyc, gnt0, gnt1, gnt_at.exists(cyc) ? gnt_at[cyc] : -1);
      end
      exp_v = valid_at.exists(cyc);
      exp_busy = gnt_at.exists(cyc) || exp_v;
      checks++;
      if (out_valid !== exp_v || busy !== exp_busy) begin
        errors++;
        $display("FAIL rand_valid cyc=%0d: valid=%b busy=%b, want %b %b",
                 cyc, out_valid, busy, exp_v, exp_busy);
      end
      if (exp_v && exp_q.size() != 0) begin
        ent = exp_q.pop_front();
        hold = ent[W-1:0];
        checks++;
        if (out_id !== ent[W]) begin
          errors++;
          $display("FAIL rand_id cyc=%0d: out_id=%b want %b", cyc, out_id, ent[W]);
        end
      end
      checks++;
      if (out !== hold) begin
        errors++;
        $display("FAIL rand_out cyc=%0d: out=%h want %h", cyc, out, hold);
      end
      if (gnt_at.exists(cyc)) begin
        if (gnt_at[cyc] == 0) begin req0 = 0; dropped0 = 1; end
        else begin req1 = 0; dropped1 = 1; end
        gnt_at.delete(cyc);
      end
      if (exp_v) valid_at.delete(cyc);
      if (accepted < 10000) begin
        if (!req0 && !dropped0 && $urandom_range(0, 3) != 0)
          drive_req(0, 2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
        if (!req1 && !dropped1 && $urandom_range(0, 3) != 0)
          drive_req(1, 2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
      end
      if (cyc >= next_free && (req0 || req1)) begin
`ifdef LOGIC16_ARB_FIXED_PRIO_EN
        w = req0 ? 0 : 1;
`else
        w = (req0 && req1) ? 1 - last_w : (req0 ? 0 : 1);
`endif
        last_w = w;
        gnt_at[cyc + 1] = w;
        valid_at[cyc + 2] = 1'b1;
        if (w == 0) exp_q.push_back({1'b0, model_op(op0, a0, b0)});
        else exp_q.push_back({1'b1, model_op(op1, a1, b1)});
        next_free = cyc + 3;
        accepted++;
      end
    end
    checks++;
    if (cyc >= 60000 || accepted < 10000) begin
      errors++;
      $display("FAIL rand_budget: cycles=%0d accepted=%0d pending=%0d, want 10000 ops done",
               cyc, accepted, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_reset_mid();
    test_tie();
    test_opcodes();
    test_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
